// File: rtl/seg7_note_fmt.sv
// Formats a tuner sample (note, octave, signed cents) into eight ASCII digit writes for a 7-segment driver.
// Optional macro SEG7_CENTS_EN enables the cents field (sign, tens, ones); without it digits 2..0 are blank.
module seg7_note_fmt #(
  parameter int WR_GAP = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] note,
  input  logic [3:0] octave,
  input  logic [7:0] cents,
  output logic       en,
  output logic [2:0] seg7id,
  output logic [7:0] ascii,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
`ifdef SEG7_CENTS_EN
  localparam logic [1:0] CONV  = 2'd1;
`endif
  localparam logic [1:0] WRITE = 2'd2;
  localparam int GW = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;

  logic [1:0]    state;
  logic [3:0]    note_q;
  logic [3:0]    oct_q;
  logic [2:0]    dig;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    char_w;

`ifdef SEG7_CENTS_EN
  logic [7:0] cents_q;
  logic [3:0] tens;
  logic [6:0] rem;
  logic [7:0] cents_neg;
  logic [7:0] mag8;
  logic [6:0] mag;

  // -128 negates to 128, which the clamp folds to 99 like every other large magnitude
  assign cents_neg = 8'd0 - cents;
  assign mag8      = cents[7] ? cents_neg : cents;
  assign mag       = (mag8 > 8'd99) ? 7'd99 : mag8[6:0];
`else
  logic unused_cents;
  assign unused_cents = ^cents;
`endif

  assign in_ready = resetn && (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    char_w = 8'h20;
    case (dig)
      3'd7: begin
        case (note_q)
          4'd0, 4'd1:  char_w = 8'h43;
          4'd2, 4'd3:  char_w = 8'h44;
          4'd4:        char_w = 8'h45;
          4'd5, 4'd6:  char_w = 8'h46;
          4'd7, 4'd8:  char_w = 8'h47;
          4'd9, 4'd10: char_w = 8'h41;
          4'd11:       char_w = 8'h42;
          default:     char_w = 8'h2D;
        endcase
      end
      3'd6: begin
        if (note_q >= 4'd12) char_w = 8'h2D;
        else begin
          case (note_q)
            4'd1, 4'd3, 4'd6, 4'd8, 4'd10: char_w = 8'h23;
            default:                       char_w = 8'h20;
          endcase
        end
      end
      3'd5: char_w = (oct_q > 4'd9) ? 8'h2D : {4'h3, oct_q};
`ifdef SEG7_CENTS_EN
      3'd2: begin
        if (cents_q == 8'd0)  char_w = 8'h20;
        else if (cents_q[7])  char_w = 8'h2D;
        else                  char_w = 8'h2B;
      end
      3'd1: char_w = (tens == 4'd0) ? 8'h20 : {4'h3, tens};
      3'd0: char_w = {4'h3, rem[3:0]};
`endif
      default: char_w = 8'h20;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      en      <= 1'b0;
      seg7id  <= 3'd0;
      ascii   <= 8'h20;
      dig     <= 3'd7;
      gap_cnt <= '0;
      note_q  <= 4'd0;
      oct_q   <= 4'd0;
`ifdef SEG7_CENTS_EN
      cents_q <= 8'd0;
      tens    <= 4'd0;
      rem     <= 7'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          en <= 1'b0;
          if (in_valid) begin
            note_q  <= note;
            oct_q   <= octave;
            dig     <= 3'd7;
            gap_cnt <= '0;
`ifdef SEG7_CENTS_EN
            cents_q <= cents;
            tens    <= 4'd0;
            rem     <= mag;
            state   <= CONV;
`else
            state   <= WRITE;
`endif
          end
        end
`ifdef SEG7_CENTS_EN
        CONV: begin
          if (rem >= 7'd10) begin
            rem  <= rem - 7'd10;
            tens <= tens + 4'd1;
          end else begin
            state <= WRITE;
          end
        end
`endif
        WRITE: begin
          // Stay in WRITE through the cycle showing digit 0 so ready returns only after it
          if (en && seg7id == 3'd0) begin
            en    <= 1'b0;
            state <= IDLE;
          end else if (gap_cnt == '0) begin
            en      <= 1'b1;
            seg7id  <= dig;
            ascii   <= char_w;
            dig     <= dig - 3'd1;
            gap_cnt <= GW'(WR_GAP);
          end else begin
            en      <= 1'b0;
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seg7_note_fmt.md
SEG7_NOTE_FMT -- requirements
Module: seg7_note_fmt

Interface
REQ-001 The block SHALL have parameter WR_GAP, default 0, giving the number of idle cycles (en=0) inserted between consecutive display writes.
REQ-002 The block SHALL have port clk, input, 1, the rising-edge clock for all state.
REQ-003 The block SHALL have port resetn, input, 1, the synchronous active-low reset; clock is clk.
REQ-004 The block SHALL have port in_valid, input, 1, indicating that note, octave and cents are valid.
REQ-005 The block SHALL have port in_ready, output, 1, indicating the block accepts a new sample.
REQ-006 The block SHALL have port note, input, 4, the pitch class, where 0..11 = C,C#,D,D#,E,F,F#,G,G#,A,A#,B.
REQ-007 The block SHALL have port octave, input, 4, the octave number 0..9.
REQ-008 The block SHALL have port cents, input, 8, the signed two's-complement pitch deviation in cents.
REQ-009 The block SHALL have port en, output, 1, the write strobe to the 8-digit display driver.
REQ-010 The block SHALL have port seg7id, output, 3, the digit index, where 7 is the leftmost digit.
REQ-011 The block SHALL have port ascii, output, 8, the character for digit seg7id.
REQ-012 The block SHALL have port busy, output, 1, which is high whenever the state is not IDLE.

Function
REQ-013 The block SHALL complete a handshake on a cycle with in_valid=1 and in_ready=1, registering all inputs in that cycle; in_ready SHALL be 1 only in IDLE.
REQ-014 The FSM SHALL have states IDLE, CONV and WRITE; a handshake SHALL move IDLE to CONV, CONV exit SHALL move to WRITE, and completion of the 8th write SHALL move WRITE to IDLE.
REQ-015 On entry to CONV, the block SHALL form mag = |cents| clamped to 99, with -128 giving 99; CONV SHALL subtract 10 per cycle, incrementing tens, while rem >= 10, and exit on the first cycle with rem < 10; CONV duration SHALL be tens+1 cycles.
REQ-016 WRITE SHALL issue exactly 8 single-cycle en pulses with seg7id 7,6,...,0 in descending order, separated by WR_GAP idle cycles, with no gap after the last pulse.
REQ-017 Digit 7 SHALL be the note letter and digit 6 SHALL be '#' (0x23) for sharps, else space (0x20); for note >= 12 both SHALL be '-' (0x2D).
REQ-018 Digit 5 SHALL be the octave digit 0x30+octave, or '-' if octave > 9; digit 4 and digit 3 SHALL be space.
REQ-019 Digit 2 SHALL be '+' for cents > 0, '-' for cents < 0, and space for cents = 0.
REQ-020 Digit 1 SHALL be the tens digit, or space if tens = 0; digit 0 SHALL be the ones digit 0x30+rem.
REQ-021 ascii and seg7id SHALL be held stable and valid only while en=1; between pulses they SHALL retain their last values.
REQ-022 in_valid asserted while busy=1 SHALL be ignored, with no sample loss required; the upstream source holds the sample until in_ready.
REQ-023 Minimum handshake-to-last-write latency SHALL be 1 + (tens+1) + 8 + 7*WR_GAP cycles, and in_ready SHALL return in the cycle after the last pulse.

Reset
REQ-024 While resetn=0, the block SHALL set state=IDLE, en=0, seg7id=0, ascii=0x20, in_ready=0, busy=0, tens=0 and rem=0; in_ready SHALL be 1 in the first cycle after reset release.
REQ-025 Reset asserted mid-CONV or mid-WRITE SHALL abort the operation with no further en pulses, and partially written digits SHALL NOT be rewritten.

Configuration
REQ-026 With macro SEG7_CENTS_EN defined, cents formatting SHALL be as in REQ-015 and REQ-019..REQ-020.
REQ-027 Without SEG7_CENTS_EN, the CONV state and cents logic SHALL be absent, a handshake SHALL go directly to WRITE, digits 2..0 SHALL be written as space, and cents SHALL be ignored.

Verification
REQ-028 The bench SHALL check: note=9, octave=4, cents=+12, WR_GAP=0 -> 8 consecutive en pulses with ids 7..0 and chars 'A',' ','4',' ',' ','+','1','2'; CONV lasts 2 cycles.
REQ-029 The bench SHALL check: note=1, octave=3, cents=-5 -> 'C','#','3',' ',' ','-',' ','5'.
REQ-030 The bench SHALL check: note=13, octave=11, cents=-128 -> '-','-','-',' ',' ','-','9','9'; CONV lasts 10 cycles.
REQ-031 The bench SHALL check: WR_GAP=3 with cents=0 -> pulses spaced 4 cycles, digit 2 = space, digit 0 = '0', and in_ready high the cycle after the 8th pulse.
REQ-032 The bench SHALL check: resetn pulled low after the 3rd write -> no further en, in_ready=0 during reset, and in_ready=1 one cycle after release.
REQ-033 The bench SHALL check: in_valid held high throughout a 10-cycle busy period -> exactly one sample accepted, and the second handshake occurs only after IDLE.
